param_seq_divider: RTL and testbench

Parametrised multi-cycle divider with integrated control FSM and shift/subtract datapath. Performs one restoring-division step per cycle over WIDTH cycles. Supports unsigned and optional signed operation, divide-by-zero handling and a run/rdy handshake. Serves as the next-generation divide unit alongside the ALU, replacing the fixed 32-bit control-plus-shift-register divider.

---
 rtl/param_seq_divider_if.sv | 25 ++
 rtl/param_seq_divider.sv | 153 +++++++++++++++
 tb/tb_param_seq_divider.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/param_seq_divider_if.sv
// Operand/result bundle for param_seq_divider: run/rdy start-and-result handshake plus busy and divide-by-zero status.
// master drives operands and run; slave (the divider) returns registered results.
interface param_seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             run;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             rdy;
    logic             busy;
    logic             div_by_zero;

    modport master (
        output run, signed_mode, dividend, divisor,
        input  quotient, remainder, rdy, busy, div_by_zero
    );

    modport slave (
        input  run, signed_mode, dividend, divisor,
        output quotient, remainder, rdy, busy, div_by_zero
    );
endinterface

// File: rtl/param_seq_divider.sv
// Restoring sequential divider, one quotient bit per cycle; WIDTH+1 cycles accept-to-rdy (1 for divide-by-zero).
// No backpressure: run is accepted only in IDLE, ignored while busy; results hold until the next op completes.
module param_seq_divider #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    param_seq_divider_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT1 = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_n_q, neg_n_d;
    logic             neg_d_q, neg_d_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             rdy_q, rdy_d;
    logic             dz_out_q, dz_out_d;

    logic             sgn_in;
    logic             in_neg_n;
    logic             in_neg_d;
    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] diff;

    assign sgn_in   = SIGNED_EN & bus.signed_mode;
    assign in_neg_n = sgn_in & bus.dividend[WIDTH-1];
    assign in_neg_d = sgn_in & bus.divisor[WIDTH-1];

    // R < D always holds between steps, so the shifted value fits in WIDTH+1 bits
    // and the extra top bit of diff is a reliable borrow/sign flag.
    assign r_sh = {r_q, q_q[WIDTH-1]};
    assign diff = r_sh - {2'b00, d_q};

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        neg_n_d  = neg_n_q;
        neg_d_d  = neg_d_q;
        dbz_d    = dbz_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        rdy_d    = rdy_q;
        dz_out_d = dz_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    neg_n_d  = in_neg_n;
                    neg_d_d  = in_neg_d;
                    q_d      = in_neg_n ? negate(bus.dividend) : bus.dividend;
                    d_d      = in_neg_d ? negate(bus.divisor) : bus.divisor;
                    r_d      = '0;
                    cnt_d    = '0;
                    rdy_d    = 1'b0;
                    dz_out_d = 1'b0;
                    dbz_d    = (bus.divisor == '0);
                    state_d  = (bus.divisor == '0) ? S_FIXUP : S_ITER;
                end
            end

            S_ITER: begin
                if (diff[WIDTH+1]) begin
                    r_d = r_sh[WIDTH:0];
                end else begin
                    r_d = diff[WIDTH:0];
                end
                q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH+1]};
                cnt_d = cnt_q + CNT1;
                if (cnt_q == LAST) begin
                    state_d = S_FIXUP;
                end
            end

            S_FIXUP: begin
                // On divide-by-zero Q still holds |dividend|; re-applying the sign recovers the original value.
                if (dbz_q) begin
                    quot_d = '1;
                    rem_d  = neg_n_q ? negate(q_q) : q_q;
                end else begin
                    quot_d = (neg_n_q ^ neg_d_q) ? negate(q_q) : q_q;
                    rem_d  = neg_n_q ? negate(r_q[WIDTH-1:0]) : r_q[WIDTH-1:0];
                end
                rdy_d    = 1'b1;
                dz_out_d = dbz_q;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            neg_n_q  <= 1'b0;
            neg_d_q  <= 1'b0;
            dbz_q    <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            rdy_q    <= 1'b0;
            dz_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            neg_n_q  <= neg_n_d;
            neg_d_q  <= neg_d_d;
            dbz_q    <= dbz_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            rdy_q    <= rdy_d;
            dz_out_q <= dz_out_d;
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.rdy         = rdy_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.div_by_zero = dz_out_q;

endmodule

// File: tb/tb_param_seq_divider.sv
// Bench for param_seq_divider: directed 8-bit cases (signed and unsigned builds) plus a 32-bit randomised run
// against an arithmetic reference model.
module tb_param_seq_divider;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    param_seq_divider_if #(.WIDTH(8))  i8s ();
    param_seq_divider_if #(.WIDTH(8))  i8u ();
    param_seq_divider_if #(.WIDTH(32)) i32 ();

    param_seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) u_div8s (
        .clk(clk), .rst_n(rst_n), .bus(i8s.slave)
    );
    param_seq_divider #(.WIDTH(8), .SIGNED_EN(1'b0)) u_div8u (
        .clk(clk), .rst_n(rst_n), .bus(i8u.slave)
    );
    param_seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) u_div32 (
        .clk(clk), .rst_n(rst_n), .bus(i32.slave)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int u, input logic run, input logic sm, input logic [31:0] a, input logic [31:0] b);
        case (u)
            0: begin i8s.run = run; i8s.signed_mode = sm; i8s.dividend = a[7:0]; i8s.divisor = b[7:0]; end
            1: begin i8u.run = run; i8u.signed_mode = sm; i8u.dividend = a[7:0]; i8u.divisor = b[7:0]; end
            default: begin i32.run = run; i32.signed_mode = sm; i32.dividend = a; i32.divisor = b; end
        endcase
    endtask

    task automatic sample(input int u, output logic rdy, output logic busy, output logic dz,
                          output logic [31:0] q, output logic [31:0] r);
        case (u)
            0: begin rdy = i8s.rdy; busy = i8s.busy; dz = i8s.div_by_zero;
                     q = {24'd0, i8s.quotient}; r = {24'd0, i8s.remainder}; end
            1: begin rdy = i8u.rdy; busy = i8u.busy; dz = i8u.div_by_zero;
                     q = {24'd0, i8u.quotient}; r = {24'd0, i8u.remainder}; end
            default: begin rdy = i32.rdy; busy = i32.busy; dz = i32.div_by_zero;
                     q = i32.quotient; r = i32.remainder; end
        endcase
    endtask

    // Reference: signed division in plain 64-bit arithmetic (truncating, remainder follows dividend).
    task automatic model(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint m, sa, sb, qq, rr;
        m = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (sb == 0) begin
            q = m[31:0];
            r = sa[31:0];
            dz = 1'b1;
        end else begin
            if (sgn) begin
                if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
                if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
            end
            qq = (sa / sb) & m;
            rr = (sa % sb) & m;
            q = qq[31:0];
            r = rr[31:0];
            dz = 1'b0;
        end
    endtask

    // Counts edges after the accept edge until rdy; busy must stay high before rdy and be low with it.
    task automatic wait_done(input int u, output int lat, output bit busy_ok);
        logic rdy, busy, dz;
        logic [31:0] q, r;
        lat = 0;
        busy_ok = 1'b1;
        rdy = 1'b0;
        while (!rdy && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            sample(u, rdy, busy, dz, q, r);
            if (rdy && busy) busy_ok = 1'b0;
            if (!rdy && !busy) busy_ok = 1'b0;
        end
    endtask

    task automatic do_op(input int u, input int w, input bit sm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz, input string tag);
        logic rdy, busy, dz;
        logic [31:0] q, r, bm;
        int lat;
        bit bok;
        bm = (w == 32) ? b : (b & ((32'd1 << w) - 32'd1));
        @(negedge clk);
        drive(u, 1'b1, sm, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(u, 1'b0, sm, a, b);
        sample(u, rdy, busy, dz, q, r);
        check_val({tag, ".acc_busy"}, busy, 1'b1);
        wait_done(u, lat, bok);
        sample(u, rdy, busy, dz, q, r);
        check_val({tag, ".lat"}, lat, (bm == 0) ? 1 : w + 1);
        check_val({tag, ".busy"}, bok, 1'b1);
        check_val({tag, ".q"}, q, eq);
        check_val({tag, ".r"}, r, er);
        check_val({tag, ".dz"}, dz, edz);
    endtask

    initial begin
        logic rdy, busy, dz;
        logic [31:0] q, r, eq, er, a, b;
        logic edz;
        bit sm, bok;
        int lat;

        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) drive(u, 1'b0, 1'b0, 32'd0, 32'd0);
        #12;
        for (int u = 0; u < 3; u++) begin
            sample(u, rdy, busy, dz, q, r);
            check_val($sformatf("rst%0d.outs", u), {q, r[28:0], rdy, busy, dz}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 8, 1'b0, 32'd100, 32'd7,  32'd14,   32'd2,    1'b0, "u100_7");
        do_op(0, 8, 1'b1, 32'hF9,  32'h02, 32'hFD,   32'hFF,   1'b0, "sm7_2");
        do_op(0, 8, 1'b1, 32'h07,  32'hFE, 32'hFD,   32'h01,   1'b0, "s7_m2");
        do_op(0, 8, 1'b1, 32'h80,  32'hFF, 32'h80,   32'h00,   1'b0, "sovf");
        do_op(0, 8, 1'b0, 32'h2A,  32'h00, 32'hFF,   32'h2A,   1'b1, "dbz");
        do_op(0, 8, 1'b1, 32'hF9,  32'h00, 32'hFF,   32'hF9,   1'b1, "sdbz");
        do_op(1, 8, 1'b1, 32'hF9,  32'h02, 32'h7C,   32'h01,   1'b0, "nosgn");

        // run pulsed mid-operation must be ignored
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'd200, 32'd3);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd200, 32'd3);
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            drive(0, (lat == 4), 1'b0, 32'd50, 32'd5);
            sample(0, rdy, busy, dz, q, r);
        end
        check_val("ign.lat", lat, 9);
        check_val("ign.q", q, 32'd66);
        check_val("ign.r", r, 32'd2);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'd200, 32'd3);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd200, 32'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sample(0, rdy, busy, dz, q, r);
        check_val("midrst.q", q, 32'd0);
        check_val("midrst.r", r, 32'd0);
        check_val("midrst.flags", {rdy, busy, dz}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 8, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "postrst");

        // run held high: rdy drops and busy rises on the re-accept edge
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'd100, 32'd7);
        @(posedge clk);
        @(negedge clk);
        wait_done(0, lat, bok);
        sample(0, rdy, busy, dz, q, r);
        check_val("b2b.lat1", lat, 9);
        check_val("b2b.q1", q, 32'd14);
        drive(0, 1'b1, 1'b0, 32'd9, 32'd3);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd9, 32'd3);
        sample(0, rdy, busy, dz, q, r);
        check_val("b2b.reacc", {rdy, busy}, 2'b01);
        wait_done(0, lat, bok);
        sample(0, rdy, busy, dz, q, r);
        check_val("b2b.lat2", lat, 9);
        check_val("b2b.q2", q, 32'd3);
        check_val("b2b.r2", r, 32'd0);

        for (int i = 0; i < 48; i++) begin
            a  = $urandom;
            b  = $urandom;
            sm = 1'($urandom_range(0, 1));
            case (i % 6)
                0: a = 32'd0;
                1: b = 32'd1;
                2: b = 32'd0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sm = 1'b1; end
                4: b = 32'($urandom_range(1, 255));
                default: ;
            endcase
            model(32, sm, a, b, eq, er, edz);
            do_op(2, 32, sm, a, b, eq, er, edz, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
